lighting_scheduler: RTL and testbench
=====================================

Name: lighting_scheduler

Overview:
- Sequencer for the LightingSystem datapath.
- Drives its one-hot time code `tcode` through MORNING→NOON→EVENING→NIGHT on a programmable tick timer.
- Gates user light-level updates (`ulight`) to phase boundaries and latches room length (`lenght`) at start.
- Soft-ramps the LightingSystem `lightnum` result into a registered `lights_on` count, one step per cycle.

Parameters:
- TICKS_PER_PHASE, 16: number of enabled clock cycles spent in each active phase (minimum 2).
- CNT_W, 8: width of the tick counter; must satisfy 2^CNT_W ≥ TICKS_PER_PHASE.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; leaves IDLE and enters MORNING.
- stop  input  1  one-cycle pulse; returns to IDLE.
- en  input  1  tick enable; the phase counter advances only when high.
- force_next  input  1  one-cycle pulse; advances the phase immediately.
- ulight_in  input  4  requested user light level.
- ulight_wr  input  1  write strobe for `ulight_in`.
- lenght_in  input  4  room length setting.
- lightnum_in  input  4  `lightnum` fed back from LightingSystem.
- tcode  output  4  one-hot time code to LightingSystem; 0000 in IDLE.
- ulight  output  4  applied user light level to LightingSystem.
- lenght  output  4  latched room length to LightingSystem.
- lights_on  output  4  ramped light count.
- phase_done  output  1  one-cycle pulse on every phase transition.
- ulight_pend  output  1  a shadow write is waiting to be applied.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. All outputs, the counter, the shadow register and `ulight_pend` clear to 0 on reset; the state resets to IDLE.
- States and `tcode`: IDLE = 0000, MORNING = 0001, NOON = 0010, EVENING = 0100, NIGHT = 1000. `tcode` is a registered decode of state.
- Transitions:
  - IDLE→MORNING on `start`.
  - MORNING→NOON→EVENING→NIGHT→MORNING, wrapping, on an advance.
  - Any state→IDLE on `stop`.
- Advance condition: (`en` && cnt == TICKS_PER_PHASE-1) || `force_next`, evaluated only in active states.
- Counter:
  - Increments when `en` is high in an active state; holds when `en` is low.
  - Clears to 0 on every transition and while IDLE.
- Priority: `stop` > `start` > advance.
  - `start` while active is ignored.
  - `force_next` coinciding with terminal count gives a single advance.
  - `force_next` in IDLE is ignored.
- `phase_done`:
  - Pulses high for exactly the cycle in which `tcode` first shows the new phase.
  - This includes IDLE→MORNING, but not entry to IDLE.
- `ulight` gating:
  - `ulight_wr` loads a shadow register and sets `ulight_pend`.
  - In an active state, `ulight` takes the shadow value at the next transition and `ulight_pend` clears.
  - In IDLE, `ulight` updates on the edge after the write and `ulight_pend` never asserts.
  - A write in the same cycle as a transition is applied at that transition.
  - A later write overwrites the pending value; the last write wins.
- `lenght`: sampled from `lenght_in` on the IDLE→MORNING edge and held constant while active.
- Ramp:
  - Target is `lightnum_in` in active states and 0 in IDLE.
  - Each cycle `lights_on` moves one step toward the target: +1 if below, -1 if above, hold if equal.
  - Unsigned 4-bit arithmetic, no wrap; 15 is the ceiling and 0 the floor.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No pending write survives reset.
- `busy`: equals (state != IDLE), registered with the state.

Test Plan:
- Phase sequencing: TICKS_PER_PHASE=4, rst then `start`, `en`=1 held → `tcode` = 0001, 0010, 0100, 1000, 0001, each for 4 cycles; `phase_done` pulses on each change; `busy`=1.
- Enable gating and force: `en` low for 3 cycles mid-MORNING → phase extended by 3 cycles. `force_next` at cnt=1 → NOON on the next edge and counter cleared. `force_next` at cnt=3 with `en`=1 → a single advance to NOON.
- Shadow write: in NOON write `ulight_in`=1101 → `ulight_pend`=1 and `ulight` unchanged until EVENING, then `ulight`=1101 and `ulight_pend`=0. Write 1001 then 0110 within one phase → 0110 is applied.
- IDLE behaviour: with `lenght_in`=1001, `start` → `lenght`=1001; change `lenght_in` while active → `lenght` stays 1001. In IDLE, a write of 1001 → `ulight`=1001 on the next cycle with `ulight_pend`=0.
- Ramp: `lightnum_in`=0110 while active and `lights_on`=0 → `lights_on` steps 1..6 over 6 cycles. `stop` → `tcode`=0000 and `lights_on` ramps back to 0.
- Simultaneous events and reset: `stop`, `start` and `force_next` in the same cycle → IDLE. Async `rst` asserted mid-EVENING (between clock edges) → all outputs 0 immediately and state IDLE.

Source files
------------

// File: rtl/lighting_scheduler.sv
// -----------------------------------------------------------------------------
// lighting_scheduler
//
// Sequencer for the LightingSystem datapath. Steps a one-hot time code through
// MORNING -> NOON -> EVENING -> NIGHT (wrapping) on a programmable tick timer.
// It also applies user light-level updates only at phase boundaries, latches the
// room length when a run starts, and soft-ramps the light count fed back from
// LightingSystem.
//
// Parameters
//   TICKS_PER_PHASE : enabled cycles spent in each active phase (>= 2)
//   CNT_W           : tick counter width, 2**CNT_W >= TICKS_PER_PHASE
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   pulse: IDLE -> MORNING
//   stop         in   pulse: any state -> IDLE
//   en           in   tick enable for the phase counter
//   force_next   in   pulse: advance the phase immediately
//   ulight_in    in   [3:0] requested user light level
//   ulight_wr    in   write strobe for ulight_in
//   lenght_in    in   [3:0] room length setting
//   lightnum_in  in   [3:0] lightnum fed back from LightingSystem
//   tcode        out  [3:0] one-hot time code, 0000 in IDLE
//   ulight       out  [3:0] applied user light level
//   lenght       out  [3:0] room length latched at start
//   lights_on    out  [3:0] ramped light count
//   phase_done   out  one-cycle pulse when tcode shows a new active phase
//   ulight_pend  out  a shadow write is waiting for the next transition
//   busy         out  high in any state other than IDLE
// -----------------------------------------------------------------------------
module lighting_scheduler #(
    parameter int TICKS_PER_PHASE = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       en,
    input  logic       force_next,
    input  logic [3:0] ulight_in,
    input  logic       ulight_wr,
    input  logic [3:0] lenght_in,
    input  logic [3:0] lightnum_in,
    output logic [3:0] tcode,
    output logic [3:0] ulight,
    output logic [3:0] lenght,
    output logic [3:0] lights_on,
    output logic       phase_done,
    output logic       ulight_pend,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MORNING = 3'd1,
        NOON    = 3'd2,
        EVENING = 3'd3,
        NIGHT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_PHASE - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       shadow;
    logic [3:0]       ramp_target;
    logic             active;
    logic             advance;
    logic             transition;

    function automatic logic [3:0] tcode_of(input state_t s);
        case (s)
            MORNING: tcode_of = 4'b0001;
            NOON:    tcode_of = 4'b0010;
            EVENING: tcode_of = 4'b0100;
            NIGHT:   tcode_of = 4'b1000;
            default: tcode_of = 4'b0000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_state = state;
        cnt_next   = cnt;
        active     = (state != IDLE);
        // force_next at terminal count still yields one advance: both terms
        // just OR into the same condition.
        advance    = active && ((en && (cnt == CNT_LAST)) || force_next);

        // stop wins over start, start over advance; start is only looked at
        // in IDLE so it is ignored while a run is in progress.
        if (stop) begin
            next_state = IDLE;
        end else if (state == IDLE) begin
            if (start) next_state = MORNING;
        end else if (advance) begin
            case (state)
                MORNING: next_state = NOON;
                NOON:    next_state = EVENING;
                EVENING: next_state = NIGHT;
                NIGHT:   next_state = MORNING;
                default: next_state = IDLE;
            endcase
        end

        transition = (next_state != state);

        if (transition || !active) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt + CNT_W'(1);
        end

        ramp_target = active ? lightnum_in : 4'd0;
    end

    // ------------------------------------------------------------------
    // State register with registered decodes
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tcode      <= 4'b0000;
            busy       <= 1'b0;
            phase_done <= 1'b0;
            lenght     <= 4'd0;
        end else begin
            state      <= next_state;
            cnt        <= cnt_next;
            tcode      <= tcode_of(next_state);
            busy       <= (next_state != IDLE);
            // Entering IDLE is not a phase, so it never pulses.
            phase_done <= transition && (next_state != IDLE);
            if ((state == IDLE) && (next_state == MORNING)) begin
                lenght <= lenght_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // User light level: shadow register applied at phase boundaries
    // ------------------------------------------------------------------
    // NOTE: the shadow register is reset along with everything else so a
    // write made before reset can never be applied after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= 4'd0;
            ulight      <= 4'd0;
            ulight_pend <= 1'b0;
        end else if (!active) begin
            // Nothing to synchronise to in IDLE: apply straight away.
            if (ulight_wr) begin
                shadow <= ulight_in;
                ulight <= ulight_in;
            end
            ulight_pend <= 1'b0;
        end else if (transition) begin
            // A write coinciding with the boundary is the newest value.
            if (ulight_wr) begin
                shadow <= ulight_in;
                ulight <= ulight_in;
            end else if (ulight_pend) begin
                ulight <= shadow;
            end
            ulight_pend <= 1'b0;
        end else if (ulight_wr) begin
            shadow      <= ulight_in;
            ulight_pend <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Soft ramp of the light count, one step per cycle
    // ------------------------------------------------------------------
    // The compare-then-step form cannot wrap: it only increments below the
    // target and only decrements above it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lights_on <= 4'd0;
        end else if (lights_on < ramp_target) begin
            lights_on <= lights_on + 4'd1;
        end else if (lights_on > ramp_target) begin
            lights_on <= lights_on - 4'd1;
        end
    end

endmodule

// File: tb/tb_lighting_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lighting_scheduler
//
// Directed testbench for lighting_scheduler with TICKS_PER_PHASE = 4. Inputs
// are changed 1 ns after a rising edge and outputs are checked at that same
// point, so each check sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_lighting_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       en = 1'b0;
    logic       force_next = 1'b0;
    logic [3:0] ulight_in = 4'd0;
    logic       ulight_wr = 1'b0;
    logic [3:0] lenght_in = 4'd0;
    logic [3:0] lightnum_in = 4'd0;
    logic [3:0] tcode;
    logic [3:0] ulight;
    logic [3:0] lenght;
    logic [3:0] lights_on;
    logic       phase_done;
    logic       ulight_pend;
    logic       busy;

    int errors = 0;
    int checks = 0;

    lighting_scheduler #(
        .TICKS_PER_PHASE(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .en(en),
        .force_next(force_next),
        .ulight_in(ulight_in),
        .ulight_wr(ulight_wr),
        .lenght_in(lenght_in),
        .lightnum_in(lightnum_in),
        .tcode(tcode),
        .ulight(ulight),
        .lenght(lenght),
        .lights_on(lights_on),
        .phase_done(phase_done),
        .ulight_pend(ulight_pend),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        en          = 1'b0;
        force_next  = 1'b0;
        ulight_wr   = 1'b0;
        ulight_in   = 4'd0;
        lenght_in   = 4'd0;
        lightnum_in = 4'd0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({tcode, ulight, lenght, lights_on, phase_done, ulight_pend, busy} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got tcode=%b ulight=%b lenght=%b lights_on=%0d pd=%b pend=%b busy=%b, want all 0",
                     tcode, ulight, lenght, lights_on, phase_done, ulight_pend, busy);
        end
        do_reset();
    endtask

    task automatic test_sequencing();
        logic [3:0] exp_tcode;
        do_reset();
        en        = 1'b1;
        lenght_in = 4'b1001;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            exp_tcode = 4'b0001 << ((k / 4) % 4);
            checks++;
            if (tcode !== exp_tcode) begin
                errors++;
                $display("FAIL seq_tcode k=%0d: got %b want %b", k, tcode, exp_tcode);
            end
            checks++;
            if (phase_done !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL seq_phase_done k=%0d: got %b want %b", k, phase_done, (k % 4) == 0);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL seq_busy k=%0d: got %b want 1", k, busy);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({tcode, busy, phase_done} !== 6'd0) begin
            errors++;
            $display("FAIL seq_stop: got tcode=%b busy=%b pd=%b want 0000 0 0", tcode, busy, phase_done);
        end
    endtask

    task automatic test_enable_force();
        logic [3:0] exp_tcode;
        do_reset();
        en    = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        // en low for edges 2..4: MORNING stretches from 4 to 7 cycles.
        for (int i = 1; i <= 7; i++) begin
            en = !(i >= 2 && i <= 4);
            step();
            exp_tcode = (i < 7) ? 4'b0001 : 4'b0010;
            checks++;
            if (tcode !== exp_tcode || phase_done !== (i == 7)) begin
                errors++;
                $display("FAIL en_gate edge=%0d: got tcode=%b pd=%b want tcode=%b pd=%b",
                         i, tcode, phase_done, exp_tcode, i == 7);
            end
        end
        en = 1'b1;
        step();             // NOON, cnt=1
        force_next = 1'b1;
        step();             // forced to EVENING, cnt cleared
        force_next = 1'b0;
        checks++;
        if (tcode !== 4'b0100 || phase_done !== 1'b1) begin
            errors++;
            $display("FAIL force_early: got tcode=%b pd=%b want 0100 1", tcode, phase_done);
        end
        // Full 4-cycle EVENING proves the counter was cleared by the force.
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_tcode = (i < 4) ? 4'b0100 : 4'b1000;
            checks++;
            if (tcode !== exp_tcode) begin
                errors++;
                $display("FAIL force_cnt_clear i=%0d: got %b want %b", i, tcode, exp_tcode);
            end
        end
        step();
        step();
        step();             // NIGHT, cnt=3
        force_next = 1'b1;
        step();             // terminal count and force together
        force_next = 1'b0;
        checks++;
        if (tcode !== 4'b0001 || phase_done !== 1'b1) begin
            errors++;
            $display("FAIL force_terminal: got tcode=%b pd=%b want 0001 1", tcode, phase_done);
        end
        step();
        checks++;
        if (tcode !== 4'b0001 || phase_done !== 1'b0) begin
            errors++;
            $display("FAIL force_single_adv: got tcode=%b pd=%b want 0001 0", tcode, phase_done);
        end
    endtask

    task automatic test_shadow_write();
        do_reset();
        en    = 1'b1;
        start = 1'b1;
        step();             // edge 0: MORNING
        start = 1'b0;
        for (int i = 1; i <= 4; i++) step();   // edge 4: NOON
        ulight_in = 4'b1101;
        ulight_wr = 1'b1;
        step();             // edge 5
        ulight_wr = 1'b0;
        for (int i = 5; i <= 7; i++) begin
            if (i > 5) step();
            checks++;
            if (ulight_pend !== 1'b1 || ulight !== 4'b0000 || tcode !== 4'b0010) begin
                errors++;
                $display("FAIL shadow_hold edge=%0d: got pend=%b ulight=%b tcode=%b want 1 0000 0010",
                         i, ulight_pend, ulight, tcode);
            end
        end
        step();             // edge 8: EVENING
        checks++;
        if (ulight !== 4'b1101 || ulight_pend !== 1'b0 || tcode !== 4'b0100) begin
            errors++;
            $display("FAIL shadow_apply: got ulight=%b pend=%b tcode=%b want 1101 0 0100",
                     ulight, ulight_pend, tcode);
        end
        ulight_in = 4'b1001;
        ulight_wr = 1'b1;
        step();             // edge 9
        ulight_in = 4'b0110;
        step();             // edge 10
        ulight_wr = 1'b0;
        checks++;
        if (ulight !== 4'b1101 || ulight_pend !== 1'b1) begin
            errors++;
            $display("FAIL shadow_overwrite_hold: got ulight=%b pend=%b want 1101 1", ulight, ulight_pend);
        end
        step();
        step();             // edge 12: NIGHT
        checks++;
        if (ulight !== 4'b0110 || ulight_pend !== 1'b0 || tcode !== 4'b1000) begin
            errors++;
            $display("FAIL shadow_last_wins: got ulight=%b pend=%b tcode=%b want 0110 0 1000",
                     ulight, ulight_pend, tcode);
        end
        step();
        step();
        step();             // edge 15: cnt=3
        ulight_in = 4'b0011;
        ulight_wr = 1'b1;
        step();             // edge 16: NIGHT -> MORNING with write
        ulight_wr = 1'b0;
        checks++;
        if (ulight !== 4'b0011 || ulight_pend !== 1'b0 || tcode !== 4'b0001) begin
            errors++;
            $display("FAIL shadow_same_cycle: got ulight=%b pend=%b tcode=%b want 0011 0 0001",
                     ulight, ulight_pend, tcode);
        end
    endtask

    task automatic test_idle();
        do_reset();
        lenght_in = 4'b1001;
        start     = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (lenght !== 4'b1001) begin
            errors++;
            $display("FAIL lenght_latch: got %b want 1001", lenght);
        end
        lenght_in = 4'b0101;
        step();
        step();
        checks++;
        if (lenght !== 4'b1001) begin
            errors++;
            $display("FAIL lenght_hold: got %b want 1001", lenght);
        end
        stop = 1'b1;
        step();
        stop      = 1'b0;
        ulight_in = 4'b1001;
        ulight_wr = 1'b1;
        step();
        ulight_wr = 1'b0;
        checks++;
        if (ulight !== 4'b1001 || ulight_pend !== 1'b0) begin
            errors++;
            $display("FAIL idle_write: got ulight=%b pend=%b want 1001 0", ulight, ulight_pend);
        end
        force_next = 1'b1;
        step();
        force_next = 1'b0;
        checks++;
        if (tcode !== 4'b0000 || busy !== 1'b0 || phase_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_force_ignored: got tcode=%b busy=%b pd=%b want 0000 0 0", tcode, busy, phase_done);
        end
    endtask

    task automatic test_ramp();
        int exp_l;
        do_reset();
        lightnum_in = 4'b0110;
        start       = 1'b1;
        step();             // edge 0: target was still 0 (IDLE)
        start = 1'b0;
        for (int i = 0; i <= 7; i++) begin
            if (i > 0) step();
            exp_l = (i < 6) ? i : 6;
            checks++;
            if (lights_on !== 4'(exp_l)) begin
                errors++;
                $display("FAIL ramp_up i=%0d: got %0d want %0d", i, lights_on, exp_l);
            end
        end
        stop = 1'b1;
        step();             // edge S0: target still 6 during this cycle
        stop = 1'b0;
        checks++;
        if (tcode !== 4'b0000) begin
            errors++;
            $display("FAIL ramp_stop_tcode: got %b want 0000", tcode);
        end
        for (int i = 0; i <= 7; i++) begin
            if (i > 0) step();
            exp_l = (i < 6) ? 6 - i : 0;
            checks++;
            if (lights_on !== 4'(exp_l)) begin
                errors++;
                $display("FAIL ramp_down i=%0d: got %0d want %0d", i, lights_on, exp_l);
            end
        end
        lightnum_in = 4'd15;
        start       = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (lights_on !== 4'd15) begin
            errors++;
            $display("FAIL ramp_ceiling: got %0d want 15", lights_on);
        end
        lightnum_in = 4'd12;
        step();
        checks++;
        if (lights_on !== 4'd14) begin
            errors++;
            $display("FAIL ramp_step_down: got %0d want 14", lights_on);
        end
        step();
        step();
        step();
        checks++;
        if (lights_on !== 4'd12) begin
            errors++;
            $display("FAIL ramp_settle: got %0d want 12", lights_on);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        stop       = 1'b1;
        start      = 1'b1;
        force_next = 1'b1;
        step();
        checks++;
        if (tcode !== 4'b0000 || busy !== 1'b0 || phase_done !== 1'b0) begin
            errors++;
            $display("FAIL simult_active: got tcode=%b busy=%b pd=%b want 0000 0 0", tcode, busy, phase_done);
        end
        step();             // still all three asserted, now from IDLE
        stop       = 1'b0;
        start      = 1'b0;
        force_next = 1'b0;
        checks++;
        if (tcode !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL simult_idle: got tcode=%b busy=%b want 0000 0", tcode, busy);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en          = 1'b1;
        lenght_in   = 4'b0111;
        lightnum_in = 4'd5;
        start       = 1'b1;
        step();             // edge 0: MORNING
        start = 1'b0;
        for (int i = 1; i <= 8; i++) step();   // edge 8: EVENING
        ulight_in = 4'b1010;
        ulight_wr = 1'b1;
        step();             // edge 9: write pending
        ulight_wr = 1'b0;
        checks++;
        if (tcode !== 4'b0100 || ulight_pend !== 1'b1 || lights_on !== 4'd5) begin
            errors++;
            $display("FAIL pre_reset_state: got tcode=%b pend=%b lights_on=%0d want 0100 1 5",
                     tcode, ulight_pend, lights_on);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({tcode, ulight, lenght, lights_on, phase_done, ulight_pend, busy} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: got tcode=%b ulight=%b lenght=%b lights_on=%0d pd=%b pend=%b busy=%b want all 0",
                     tcode, ulight, lenght, lights_on, phase_done, ulight_pend, busy);
        end
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (ulight !== 4'd0 || ulight_pend !== 1'b0 || tcode !== 4'b0000) begin
            errors++;
            $display("FAIL reset_no_pending: got ulight=%b pend=%b tcode=%b want 0000 0 0000",
                     ulight, ulight_pend, tcode);
        end
    endtask

    initial begin
        test_reset();
        test_sequencing();
        test_enable_force();
        test_shadow_write();
        test_idle();
        test_ramp();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
